bsg_link_oddr_tx_phy: RTL and testbench

//  Output DDR PHY: transmit side of the source-synchronous DDR link. Accepts a
//  2x-wide word on a valid/ready handshake and serializes it onto a width_p
//  bus over two clk_i cycles, LSB half first, then MSB half.

---
 rtl/bsg_link_oddr_tx_phy.sv | 59 +++++
 tb/tb_bsg_link_oddr_tx_phy.sv | 131 +++++++++++++
 2 files changed

// File: rtl/bsg_link_oddr_tx_phy.sv
// Output DDR PHY: serializes a 2*width_p word LSB-first with a centre-aligned forwarded clock.
// Define BSG_LINK_ODDR_CLK_GATE_EN to hold the forwarded clock low during idle slot pairs.
module bsg_link_oddr_tx_phy #(
    parameter int width_p = 8
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   valid_i,
    input  logic [2*width_p-1:0]   data_i,
    output logic                   ready_o,
    output logic [width_p-1:0]     data_r_o,
    output logic                   clk_r_o
);

    logic               phase_r;
    logic               active_r;
    logic [width_p-1:0] hi_r;
    logic               gate;

    assign ready_o = reset_n_i & phase_r;

`ifdef BSG_LINK_ODDR_CLK_GATE_EN
    assign gate = active_r;
`else
    assign gate = 1'b1;
`endif

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            data_r_o <= '0;
            hi_r     <= '0;
            active_r <= 1'b0;
            phase_r  <= 1'b1;
        end else if (phase_r) begin
            phase_r <= 1'b0;
            if (valid_i) begin
                data_r_o <= data_i[width_p-1:0];
                hi_r     <= data_i[2*width_p-1:width_p];
                active_r <= 1'b1;
            end else begin
                data_r_o <= '0;
                active_r <= 1'b0;
            end
        end else begin
            data_r_o <= active_r ? hi_r : '0;
            phase_r  <= 1'b1;
        end
    end

    // Negedge flop puts the forwarded edges in the middle of each data slot.
    always_ff @(negedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            clk_r_o <= 1'b0;
        end else begin
            clk_r_o <= gate & ~phase_r;
        end
    end

endmodule

// File: tb/tb_bsg_link_oddr_tx_phy.sv
// Directed bench for bsg_link_oddr_tx_phy (width_p=8); idle clock expectation follows
// BSG_LINK_ODDR_CLK_GATE_EN.
module tb_bsg_link_oddr_tx_phy;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        valid;
    logic [15:0] data;
    logic        ready;
    logic [7:0]  data_r;
    logic        clk_r;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef BSG_LINK_ODDR_CLK_GATE_EN
    localparam logic IDLE_CLK = 1'b0;
`else
    localparam logic IDLE_CLK = 1'b1;
`endif

    bsg_link_oddr_tx_phy #(.width_p(8)) dut (
        .clk_i    (clk),
        .reset_n_i(reset_n),
        .valid_i  (valid),
        .data_i   (data),
        .ready_o  (ready),
        .data_r_o (data_r),
        .clk_r_o  (clk_r)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One slot: drive inputs, check ready, check data after posedge,
    // check forwarded clock after the following negedge.
    task automatic cyc(input string tag, input logic v, input logic [15:0] d,
                       input logic exp_rdy, input logic [7:0] exp_d,
                       input logic exp_clk);
        valid = v;
        data  = d;
        #1;
        chk({tag, ".ready"}, {15'b0, ready}, {15'b0, exp_rdy});
        @(posedge clk);
        #1;
        chk({tag, ".data"}, {8'b0, data_r}, {8'b0, exp_d});
        @(negedge clk);
        #1;
        chk({tag, ".clk"}, {15'b0, clk_r}, {15'b0, exp_clk});
    endtask

    initial begin
        reset_n = 1'b0;
        valid   = 1'b0;
        data    = 16'h0;

        // reset state while clocking
        repeat (3) @(posedge clk);
        #1;
        chk("rst.data", {8'b0, data_r}, 16'h0);
        @(negedge clk);
        #1;
        chk("rst.clk", {15'b0, clk_r}, 16'h0);
        chk("rst.ready", {15'b0, ready}, 16'h0);
        reset_n = 1'b1;

        // single word
        cyc("w1.lo",  1'b1, 16'hA55A, 1'b1, 8'h5A, 1'b1);
        cyc("w1.hi",  1'b0, 16'h0000, 1'b0, 8'hA5, 1'b0);
        cyc("w1.i0",  1'b0, 16'h0000, 1'b1, 8'h00, IDLE_CLK);
        cyc("w1.i1",  1'b0, 16'h0000, 1'b0, 8'h00, 1'b0);

        // back-to-back with valid held
        cyc("b2b.0",  1'b1, 16'h0201, 1'b1, 8'h01, 1'b1);
        cyc("b2b.1",  1'b1, 16'h0403, 1'b0, 8'h02, 1'b0);
        cyc("b2b.2",  1'b1, 16'h0403, 1'b1, 8'h03, 1'b1);
        cyc("b2b.3",  1'b1, 16'h0605, 1'b0, 8'h04, 1'b0);
        cyc("b2b.4",  1'b1, 16'h0605, 1'b1, 8'h05, 1'b1);
        cyc("b2b.5",  1'b0, 16'h0000, 1'b0, 8'h06, 1'b0);

        // junk while not ready is ignored
        cyc("jnk.i0", 1'b0, 16'h0000, 1'b1, 8'h00, IDLE_CLK);
        cyc("jnk.j",  1'b1, 16'hDEAD, 1'b0, 8'h00, 1'b0);
        cyc("jnk.lo", 1'b1, 16'h3C4B, 1'b1, 8'h4B, 1'b1);
        cyc("jnk.hi", 1'b0, 16'h0000, 1'b0, 8'h3C, 1'b0);

        // async reset in the MSB slot
        cyc("ar.lo",  1'b1, 16'h1122, 1'b1, 8'h22, 1'b1);
        valid = 1'b0;
        data  = 16'h0;
        @(posedge clk);
        #1;
        chk("ar.hi",     {8'b0, data_r}, 16'h0011);
        chk("ar.clkhi",  {15'b0, clk_r}, 16'h0001);
        #1;
        reset_n = 1'b0;
        #1;
        chk("ar.data0",  {8'b0, data_r}, 16'h0000);
        chk("ar.clk0",   {15'b0, clk_r}, 16'h0000);
        chk("ar.rdy0",   {15'b0, ready}, 16'h0000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("ar.hold",   {8'b0, data_r}, 16'h0000);
        reset_n = 1'b1;
        cyc("ar.w.lo", 1'b1, 16'h7788, 1'b1, 8'h88, 1'b1);
        cyc("ar.w.hi", 1'b0, 16'h0000, 1'b0, 8'h77, 1'b0);

        // two words separated by four idle cycles
        cyc("gap.i0", 1'b0, 16'h0000, 1'b1, 8'h00, IDLE_CLK);
        cyc("gap.i1", 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0);
        cyc("gap.i2", 1'b0, 16'h0000, 1'b1, 8'h00, IDLE_CLK);
        cyc("gap.i3", 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0);
        cyc("gap.lo", 1'b1, 16'hF00F, 1'b1, 8'h0F, 1'b1);
        cyc("gap.hi", 1'b0, 16'h0000, 1'b0, 8'hF0, 1'b0);
        cyc("gap.e0", 1'b0, 16'h0000, 1'b1, 8'h00, IDLE_CLK);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
